mem_stage_lsu: RTL
==================

# mem_stage_lsu

Parametrised, multi-cycle successor to the single-cycle memory stage: sits between execute (ixmem) and writeback (memwb), owns the data memory array, and performs word and byte loads/stores with a configurable access latency. While an access is in flight it stalls execute through a ready handshake. Non-memory instructions pass through one register stage to writeback.

## Interface
- DATA_W, 16, data/register width (even, ≥8)
- ADDR_W, 16, word-address width
- DEPTH, 1024, memory words implemented (≤ 2**ADDR_W)
- IDX_W, 3, destination register index width
- MEM_LAT, 2, access latency in cycles (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- valid_ixmem_p1  in  1  instruction present from execute
- ready_ixmem_p1  out  1  stage can accept this cycle
- mem_addr_ixmem_p1  in  ADDR_W  word address
- mem_data_in_ixmem_p1  in  DATA_W  store data
- ldst_valid_ixmem_p1  in  1  instruction is a load or store
- store_valid_ixmem_p1  in  2  byte enables: 00 load, 01 low byte, 10 high byte, 11 word
- dest_reg_value_ixmem_p1  in  DATA_W  ALU result for non-loads
- dest_reg_index_ixmem_p1  in  IDX_W  destination register
- dest_reg_write_valid_ixmem_p1  in  1  writes a register
- valid_memwb_p1  out  1  result valid to writeback (single-cycle pulse per instruction)
- dest_reg_value_memwb_p1  out  DATA_W  result value
- dest_reg_index_memwb_p1  out  IDX_W  result index
- dest_reg_write_valid_memwb_p1  out  1  register write enable (qualified by valid)
- err_memwb_p1  out  1  access fault (MEM_STAGE_ERR_EN only; else tied 0)

## Operation
- Accept = valid_ixmem_p1 & ready_ixmem_p1; inputs sampled only on accept.
- FSM: IDLE, BUSY. IDLE → BUSY on accepted ldst when MEM_LAT>1; BUSY holds down-counter cnt (width clog2(MEM_LAT)), loaded with MEM_LAT-2, decremented each cycle; BUSY → IDLE when cnt==0 (completion cycle).
- ready_ixmem_p1 = (state==IDLE). Never depends combinationally on valid_ixmem_p1.
- Non-ldst accept: next cycle valid_memwb=1, value/index/write_valid = registered inputs.
- Store: array write at completion edge; byte enable b writes bits [8b+7:8b] only; other bytes unchanged. Output valid with write_valid as presented (normally 0), value = dest_reg_value.
- Load: array read at completion edge (sees all earlier stores); value = full word.
- Address ≥ DEPTH without ERR_EN: address taken modulo DEPTH (low clog2(DEPTH) bits).
- Array contents not reset.

## Timing
- Reset (async assert, sync deassert assumed upstream): state=IDLE, cnt=0, valid_memwb=0, value=0, index=0, write_valid=0, err=0, ready=1.
- Non-ldst accepted cycle T → valid_memwb in cycle T+1; ready stays 1; back-to-back throughput 1/cycle.
- ldst accepted cycle T → valid_memwb cycle T+MEM_LAT; ready low cycles T+1..T+MEM_LAT-1; high again in T+MEM_LAT (next accept may coincide with output).
- MEM_LAT=1: never stalls; identical timing to non-ldst.
- Output held only one cycle; writeback always accepts.
- Reset mid-access: in-flight access aborted, store not committed, no output pulse.
- Idle cycles (valid low): valid_memwb=0 next cycle; other outputs hold last value.

## Configuration
- MEM_STAGE_ERR_EN defined: ldst with address ≥ DEPTH, or store_valid≠11 with DATA_W≠16, raises err_memwb_p1 with valid_memwb at normal completion time; store suppressed, dest_reg_write_valid_memwb_p1 forced 0. Timing unchanged.
- Not defined: err_memwb_p1 constant 0; addresses wrap modulo DEPTH.

## Test plan
- Reset: rst low mid-stream → all outputs 0, ready=1 immediately (asynchronous).
- MEM_LAT=3: store 0xBEEF to addr 5 at T, load addr 5 at T+3 → ready low T+1,T+2; load result 0xBEEF at T+6, write_valid=1.
- Byte store: word 0x1234 at addr 7, store_valid=10 data 0xAB00 → load returns 0xAB34; then 01 data 0x00CD → 0xABCD.
- Pass-through: 4 back-to-back ALU ops index 1..4 values 0x0011..0x0044 → outputs one per cycle, one cycle later, ready never low.
- ERR_EN, DEPTH=1024: store to 0x0400 → err=1, write_valid=0, addr 0 unchanged; without macro → addr 0 written.
- Abort: assert rst during BUSY of store to addr 9 → addr 9 keeps prior value, no valid_memwb pulse.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Execute-to-memory request and memory-to-writeback result bundle for mem_stage_lsu.
// master drives requests and observes results; slave is the memory stage itself.
interface mem_stage_lsu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int IDX_W  = 3
);
  logic              valid_ixmem_p1;
  logic              ready_ixmem_p1;
  logic [ADDR_W-1:0] mem_addr_ixmem_p1;
  logic [DATA_W-1:0] mem_data_in_ixmem_p1;
  logic              ldst_valid_ixmem_p1;
  logic [1:0]        store_valid_ixmem_p1;
  logic [DATA_W-1:0] dest_reg_value_ixmem_p1;
  logic [IDX_W-1:0]  dest_reg_index_ixmem_p1;
  logic              dest_reg_write_valid_ixmem_p1;
  logic              valid_memwb_p1;
  logic [DATA_W-1:0] dest_reg_value_memwb_p1;
  logic [IDX_W-1:0]  dest_reg_index_memwb_p1;
  logic              dest_reg_write_valid_memwb_p1;
  logic              err_memwb_p1;

  modport master (
    output valid_ixmem_p1, mem_addr_ixmem_p1, mem_data_in_ixmem_p1, ldst_valid_ixmem_p1,
           store_valid_ixmem_p1, dest_reg_value_ixmem_p1, dest_reg_index_ixmem_p1,
           dest_reg_write_valid_ixmem_p1,
    input  ready_ixmem_p1, valid_memwb_p1, dest_reg_value_memwb_p1, dest_reg_index_memwb_p1,
           dest_reg_write_valid_memwb_p1, err_memwb_p1
  );

  modport slave (
    input  valid_ixmem_p1, mem_addr_ixmem_p1, mem_data_in_ixmem_p1, ldst_valid_ixmem_p1,
           store_valid_ixmem_p1, dest_reg_value_ixmem_p1, dest_reg_index_ixmem_p1,
           dest_reg_write_valid_ixmem_p1,
    output ready_ixmem_p1, valid_memwb_p1, dest_reg_value_memwb_p1, dest_reg_index_memwb_p1,
           dest_reg_write_valid_memwb_p1, err_memwb_p1
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Multi-cycle memory stage: owns the data array, does word/byte loads and stores with MEM_LAT latency.
// Optional access-fault reporting is enabled by defining MEM_STAGE_ERR_EN.
//
// state | meaning
// IDLE  | ready for a new instruction; non-ldst (and all ops when MEM_LAT==1) complete here
// BUSY  | ldst in flight, cnt counts down to the completion cycle (cnt==0)
module mem_stage_lsu #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 1024,
  parameter int IDX_W   = 3,
  parameter int MEM_LAT = 2
) (
  input logic            clk,
  input logic            rst,
  mem_stage_lsu_if.slave bus
);
  localparam int MIDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (MEM_LAT > 2) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);
  localparam bit MULTI = (MEM_LAT > 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic [DATA_W-1:0] req_value;
  logic [1:0]        req_be;
  logic [IDX_W-1:0]  req_idx;
  logic              req_wv;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept, done, we;
  logic              cur_ldst, cur_store, cur_load, cur_err, cur_wv;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data, cur_value, rd_word, wr_word, wmask;
  logic [1:0]        cur_be;
  logic [IDX_W-1:0]  cur_idx;
  logic [MIDX_W-1:0] midx;
  logic              unused_addr;

  // In BUSY the completing access comes from the latched request; in IDLE straight from execute.
  always_comb begin
    accept = bus.valid_ixmem_p1 & (state == IDLE);
    if (state == BUSY) begin
      cur_ldst  = 1'b1;
      cur_addr  = req_addr;
      cur_data  = req_data;
      cur_value = req_value;
      cur_be    = req_be;
      cur_idx   = req_idx;
      cur_wv    = req_wv;
      done      = (cnt == '0);
    end else begin
      cur_ldst  = bus.ldst_valid_ixmem_p1;
      cur_addr  = bus.mem_addr_ixmem_p1;
      cur_data  = bus.mem_data_in_ixmem_p1;
      cur_value = bus.dest_reg_value_ixmem_p1;
      cur_be    = bus.store_valid_ixmem_p1;
      cur_idx   = bus.dest_reg_index_ixmem_p1;
      cur_wv    = bus.dest_reg_write_valid_ixmem_p1;
      done      = accept & (~bus.ldst_valid_ixmem_p1 | ~MULTI);
    end
    cur_store = cur_ldst & (cur_be != 2'b00);
    cur_load  = cur_ldst & (cur_be == 2'b00);
    midx      = cur_addr[MIDX_W-1:0];
    for (int i = 0; i < DATA_W; i++)
      wmask[i] = (cur_be == 2'b11) | ((i < 8) ? cur_be[0] : ((i < 16) ? cur_be[1] : 1'b0));
  end

`ifdef MEM_STAGE_ERR_EN
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  assign cur_err = cur_ldst & (({1'b0, cur_addr} >= DEPTH_EXT) |
                               (((cur_be == 2'b01) | (cur_be == 2'b10)) & (DATA_W != 16)));
`else
  assign cur_err = 1'b0;
`endif

  assign unused_addr = ^cur_addr;
  assign rd_word = mem[midx];
  assign wr_word = (rd_word & ~wmask) | (cur_data & wmask);
  // Gating with rst keeps a store from landing while reset is held.
  assign we = done & cur_store & ~cur_err & rst;
  assign bus.ready_ixmem_p1 = (state == IDLE);
  assign bus.err_memwb_p1   = err_q;

  always_ff @(posedge clk) begin
    if (we) mem[midx] <= wr_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                             <= IDLE;
      cnt                               <= '0;
      req_addr                          <= '0;
      req_data                          <= '0;
      req_value                         <= '0;
      req_be                            <= '0;
      req_idx                           <= '0;
      req_wv                            <= 1'b0;
      bus.valid_memwb_p1                <= 1'b0;
      bus.dest_reg_value_memwb_p1       <= '0;
      bus.dest_reg_index_memwb_p1       <= '0;
      bus.dest_reg_write_valid_memwb_p1 <= 1'b0;
      err_q                             <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept & bus.ldst_valid_ixmem_p1 & MULTI) begin
            state     <= BUSY;
            cnt       <= CNT_LOAD;
            req_addr  <= bus.mem_addr_ixmem_p1;
            req_data  <= bus.mem_data_in_ixmem_p1;
            req_value <= bus.dest_reg_value_ixmem_p1;
            req_be    <= bus.store_valid_ixmem_p1;
            req_idx   <= bus.dest_reg_index_ixmem_p1;
            req_wv    <= bus.dest_reg_write_valid_ixmem_p1;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
      if (done) begin
        bus.valid_memwb_p1                <= 1'b1;
        bus.dest_reg_value_memwb_p1       <= cur_load ? rd_word : cur_value;
        bus.dest_reg_index_memwb_p1       <= cur_idx;
        bus.dest_reg_write_valid_memwb_p1 <= cur_wv & ~cur_err;
        err_q                             <= cur_err;
      end else begin
        bus.valid_memwb_p1 <= 1'b0;
      end
    end
  end
endmodule
